// File: rtl/ga_gen_ctrl.sv
// Generation sequencer: streams parent pairs from one population bank through the
// crossover/mutation pipeline into the other bank. Optional `pause` stall input: GA_PAUSE_EN.
module ga_gen_ctrl #(
    parameter int POP_SIZE = 16,
    parameter int PAIR_W   = 3,
    parameter int PIPE_LAT = 2,
    parameter int NUM_GENS = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef GA_PAUSE_EN
    input  logic              pause,
`endif
    output logic              pop_rd_en,
    output logic [PAIR_W:0]   pop_rd_addr,
    output logic              pop_wr_en,
    output logic [PAIR_W:0]   pop_wr_addr,
    output logic [15:0]       pop_wr_data,
    input  logic [7:0]        mut_child1,
    input  logic [7:0]        mut_child2,
    output logic              pipe_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       gen_count,
    output logic              result_bank
);

    localparam int                DEPTH     = 1 + PIPE_LAT;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(POP_SIZE / 2 - 1);
    localparam logic [15:0]       GEN_LIMIT = 16'(NUM_GENS);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        NEXT_GEN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              rd_bank;
    logic [PAIR_W-1:0] pair_idx;
    logic [DEPTH-1:0]  track_valid;
    logic [PAIR_W-1:0] track_idx [DEPTH];
    logic              active;
    logic              stall;
    logic              tail_valid;
    logic              drain_empty;
    logic [15:0]       gen_next;

    assign active = (state == ISSUE) || (state == DRAIN);

`ifdef GA_PAUSE_EN
    assign stall = pause && active;
`else
    assign stall = 1'b0;
`endif

    assign tail_valid = track_valid[PIPE_LAT];
    // Only the tail may still be valid: it is written this cycle, so the pipe empties at the edge.
    assign drain_empty = (track_valid & ~(DEPTH'(1) << PIPE_LAT)) == '0;
    assign gen_next    = (gen_count == GEN_LIMIT) ? gen_count : gen_count + 16'd1;

    assign busy = active || (state == NEXT_GEN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            pair_idx    <= '0;
            gen_count   <= '0;
            result_bank <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        gen_count <= '0;
                        pair_idx  <= '0;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pair_idx <= (pair_idx == LAST_PAIR) ? '0 : pair_idx + PAIR_W'(1);
                    end
                end
                NEXT_GEN: begin
                    rd_bank     <= ~rd_bank;
                    result_bank <= ~rd_bank;
                    gen_count   <= gen_next;
                end
                default: ;
            endcase
        end
    end

    // Track pipe mirrors the datapath stages so each child knows its pair index on write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            track_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                track_idx[i] <= '0;
            end
        end else if (!stall) begin
            track_valid[0] <= (state == ISSUE);
            track_idx[0]   <= pair_idx;
            for (int i = 1; i < DEPTH; i++) begin
                track_valid[i] <= track_valid[i-1];
                track_idx[i]   <= track_idx[i-1];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                if (!stall && pair_idx == LAST_PAIR) state_next = DRAIN;
            end
            DRAIN: begin
                if (!stall && drain_empty) state_next = NEXT_GEN;
            end
            NEXT_GEN: begin
                state_next = (gen_next == GEN_LIMIT) ? DONE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop_rd_en   = 1'b0;
        pop_rd_addr = '0;
        pop_wr_en   = 1'b0;
        pop_wr_addr = '0;
        pop_wr_data = '0;
        pipe_en     = active && !stall;
        if (state == ISSUE && !stall) begin
            pop_rd_en   = 1'b1;
            pop_rd_addr = {rd_bank, pair_idx};
        end
        if (tail_valid && !stall) begin
            pop_wr_en   = 1'b1;
            pop_wr_addr = {~rd_bank, track_idx[PIPE_LAT]};
            pop_wr_data = {mut_child1, mut_child2};
        end
    end

endmodule

// File: tb/tb_ga_gen_ctrl.sv
// Bench for ga_gen_ctrl: model RAM and mutation stage around the DUT, expected strobes,
// addresses and children derived per cycle from the generation schedule. Honours GA_PAUSE_EN.
module tb_ga_gen_ctrl;

    localparam int G      = 3;
    localparam int PERIOD = 12;

`ifdef GA_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic        pop_rd_en;
    logic [3:0]  pop_rd_addr;
    logic        pop_wr_en;
    logic [3:0]  pop_wr_addr;
    logic [15:0] pop_wr_data;
    logic [7:0]  mut_child1;
    logic [7:0]  mut_child2;
    logic        pipe_en;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic        result_bank;

    logic [15:0] mem    [16];
    logic [15:0] golden [16];
    logic [15:0] ram_q;
    logic [15:0] stage1;
    logic [15:0] stage2;
    logic        load_req;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ga_gen_ctrl #(
        .POP_SIZE(16),
        .PAIR_W  (3),
        .PIPE_LAT(2),
        .NUM_GENS(G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef GA_PAUSE_EN
        .pause      (pause),
`endif
        .pop_rd_en  (pop_rd_en),
        .pop_rd_addr(pop_rd_addr),
        .pop_wr_en  (pop_wr_en),
        .pop_wr_addr(pop_wr_addr),
        .pop_wr_data(pop_wr_data),
        .mut_child1 (mut_child1),
        .mut_child2 (mut_child2),
        .pipe_en    (pipe_en),
        .busy       (busy),
        .done       (done),
        .gen_count  (gen_count),
        .result_bank(result_bank)
    );

    function automatic logic [15:0] mutate(input logic [15:0] w);
        return {w[15:8] + 8'd3, w[7:0] ^ 8'hA5};
    endfunction

    assign mut_child1 = stage2[15:8];
    assign mut_child2 = stage2[7:0];

    // Population RAM (1-cycle read) followed by a two-stage crossover/mutation stand-in.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= golden[i];
        end else if (pop_wr_en) begin
            mem[pop_wr_addr] <= pop_wr_data;
        end
        if (pop_rd_en) ram_q <= mem[pop_rd_addr];
        if (pipe_en) begin
            stage1 <= mutate(ram_q);
            stage2 <= stage1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic init_population();
        for (int i = 0; i < 16; i++) golden[i] = 16'($urandom);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, " rd_en"}, 32'(pop_rd_en), 32'd0);
        checkOutput({tag, " wr_en"}, 32'(pop_wr_en), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " pipe_en"}, 32'(pipe_en), 32'd0);
    endtask

    // One run of G generations starting from bank0; abort_at>0 pulls reset in that cycle.
    task automatic applyStimulus(input logic bank0, input bit random_start, input int abort_at);
        int   eff;
        int   p;
        int   g;
        int   loc;
        int   src;
        int   dst;
        logic bank;
        bit   stall;
        bit   fin;
        bit   rd_exp;
        bit   wr_exp;
        eff = 0;
        fin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            pause = 1'b0;
            p     = eff + 1;
            if (abort_at == cyc) begin
                reset = 1'b0;
                #1;
                checkOutput("abort wr_en", 32'(pop_wr_en), 32'd0);
                check_quiet("abort");
                checkOutput("abort done", 32'(done), 32'd0);
                checkOutput("abort gen_count", 32'(gen_count), 32'd0);
                checkOutput("abort result_bank", 32'(result_bank), 32'd0);
                return;
            end
            if (p > G * PERIOD) begin
                @(negedge clk);
                fin = 1'b1;
                check_quiet("final");
                checkOutput("final done", 32'(done), 32'd1);
                checkOutput("final gen_count", 32'(gen_count), 32'(G));
                checkOutput("final result_bank", 32'(result_bank), 32'(bank0 ^ 1'(G % 2)));
                for (int i = 0; i < 16; i++) begin
                    checkOutput($sformatf("ram word %0d", i), 32'(mem[i]), 32'(golden[i]));
                end
            end else begin
                g    = (p - 1) / PERIOD;
                loc  = (p - 1) % PERIOD + 1;
                bank = bank0 ^ 1'(g % 2);
                src  = bank ? 8 : 0;
                dst  = bank ? 0 : 8;
                if (random_start) start = ($urandom_range(0, 2) == 0);
                if (HAS_PAUSE) pause = (cyc >= 4 && cyc <= 8) || ($urandom_range(0, 4) == 0);
                stall  = pause && (loc <= 11);
                rd_exp = !stall && (loc <= 8);
                wr_exp = !stall && (loc >= 4) && (loc <= 11);
                @(negedge clk);
                checkOutput($sformatf("rd_en c%0d", cyc), 32'(pop_rd_en), 32'(rd_exp));
                if (rd_exp) begin
                    checkOutput($sformatf("rd_addr c%0d", cyc), 32'(pop_rd_addr), 32'(src + loc - 1));
                end
                checkOutput($sformatf("wr_en c%0d", cyc), 32'(pop_wr_en), 32'(wr_exp));
                if (wr_exp) begin
                    checkOutput($sformatf("wr_addr c%0d", cyc), 32'(pop_wr_addr), 32'(dst + loc - 4));
                    checkOutput($sformatf("wr_data c%0d", cyc), 32'(pop_wr_data),
                                32'(mutate(golden[src + loc - 4])));
                end
                checkOutput($sformatf("pipe_en c%0d", cyc), 32'(pipe_en), 32'(!stall && loc <= 11));
                checkOutput($sformatf("busy c%0d", cyc), 32'(busy), 32'd1);
                checkOutput($sformatf("done c%0d", cyc), 32'(done), 32'd0);
                checkOutput($sformatf("gen_count c%0d", cyc), 32'(gen_count), 32'(g));
                if (!stall) begin
                    eff++;
                    if (loc == PERIOD) begin
                        for (int i = 0; i < 8; i++) golden[dst + i] = mutate(golden[src + i]);
                    end
                end
            end
        end
        if (!fin) checkOutput("run timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        load_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset gen_count", 32'(gen_count), 32'd0);
        checkOutput("reset result_bank", 32'(result_bank), 32'd0);
        checkOutput("reset wr_data", 32'(pop_wr_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        init_population();
        $display("[TB] run from idle, bank 0");
        applyStimulus(1'b0, 1'b0, 0);
        $display("[TB] run from done, bank 1, start pulses while busy");
        applyStimulus(1'b1, 1'b1, 0);
        $display("[TB] run aborted by reset during generation 2");
        applyStimulus(1'b0, 1'b1, 18);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_quiet("post-reset");
        checkOutput("post-reset gen_count", 32'(gen_count), 32'd0);
        init_population();
        $display("[TB] clean run after reset, bank 0");
        applyStimulus(1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
